// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative HI/LO multiply/divide unit in the style of a MIPS integer core.
// A multiply or divide runs one radix-2 step per cycle on operand magnitudes
// for WIDTH cycles. One FIX cycle then applies the sign correction and
// updates HI/LO. MTHI/MTLO write HI/LO directly when start is seen in IDLE.
//
// Configuration macro: MULDIV_DIVIDE_EN
//   Defined   : DIV/DIVU supported (restoring divider built).
//   Undefined : DIV/DIVU reported as illegal; no divide hardware.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request valid, sampled only in IDLE
//   funct    in   [5:0] MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B,
//                 MTHI 0x11, MTLO 0x13
//   a        in   [WIDTH-1:0] rs / dividend / MTHI-MTLO data
//   b        in   [WIDTH-1:0] rt / divisor
//   busy     out  operation in flight (stall source)
//   done     out  one-cycle pulse, new hi/lo visible
//   illegal  out  one-cycle pulse, start with unsupported funct
//   hi, lo   out  [WIDTH-1:0] registered HI/LO
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_RUN     = 2'd1;
    localparam logic [1:0]      S_FIX     = 2'd2;
    localparam logic [5:0]      F_MULT    = 6'h18;
    localparam logic [5:0]      F_MULTU   = 6'h19;
    localparam logic [5:0]      F_DIV     = 6'h1A;
    localparam logic [5:0]      F_DIVU    = 6'h1B;
    localparam logic [5:0]      F_MTHI    = 6'h11;
    localparam logic [5:0]      F_MTLO    = 6'h13;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      r_cnt;
    // Working register: multiply {partial product, multiplier},
    // divide {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;     // |b|: multiplicand or divisor
    logic               r_neg;     // negate product / quotient in FIX
    logic               r_busy;
    logic               r_done;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
`ifdef MULDIV_DIVIDE_EN
    logic               r_is_div;
    logic               r_neg_rem; // remainder takes the dividend's sign
    logic               r_dz;      // divide by zero: bypass the sign fix
    logic [WIDTH-1:0]   r_a;       // original dividend, returned in HI on /0
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_sub;
    logic [2*WIDTH-1:0] w_div_step;
`endif

    logic               w_op_mul;
    logic               w_op_div;
    logic               w_op_signed;
    logic               w_op_mthi;
    logic               w_op_mtlo;
    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_add_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_illegal_nxt;

    // Decode funct into operation classes.
    always_comb begin
        w_op_mul    = 1'b0;
        w_op_div    = 1'b0;
        w_op_signed = 1'b0;
        w_op_mthi   = 1'b0;
        w_op_mtlo   = 1'b0;
        case (funct)
            F_MULT:  begin w_op_mul = 1'b1; w_op_signed = 1'b1; end
            F_MULTU: begin w_op_mul = 1'b1; end
`ifdef MULDIV_DIVIDE_EN
            F_DIV:   begin w_op_div = 1'b1; w_op_signed = 1'b1; end
            F_DIVU:  begin w_op_div = 1'b1; end
`endif
            F_MTHI:  begin w_op_mthi = 1'b1; end
            F_MTLO:  begin w_op_mtlo = 1'b1; end
            default: begin w_op_mul = 1'b0; end
        endcase
    end

    // Operand magnitudes and acceptance of an iterative operation.
    always_comb begin
        w_accept = start && (r_state == S_IDLE) && (w_op_mul || w_op_div);
        w_a_neg  = w_op_signed & a[WIDTH-1];
        w_b_neg  = w_op_signed & b[WIDTH-1];
        w_a_mag  = w_a_neg ? -a : a;
        w_b_mag  = w_b_neg ? -b : b;
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        w_add_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_mul_step = {w_add_sum, r_acc[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
        // Shift {remainder, dividend msb} left, try subtracting the divisor.
        w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_sub      = w_rem_sh - {1'b0, r_opb};
        if (w_sub[WIDTH]) begin
            w_div_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_div_step = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
        w_step = r_is_div ? w_div_step : w_mul_step;
`else
        w_step = w_mul_step;
`endif
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        w_prod_fix = r_neg ? -r_acc : r_acc;
        w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fix   = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
        if (r_dz) begin
            w_hi_fix = r_a;
            w_lo_fix = {WIDTH{1'b1}};
        end else if (r_is_div) begin
            w_hi_fix = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_lo_fix = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else begin
            w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = (r_cnt == LAST_ITER) ? S_FIX : S_RUN;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead and registered.
    always_comb begin
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (r_state == S_FIX);
        w_illegal_nxt = start && (r_state == S_IDLE)
                     && !(w_op_mul || w_op_div || w_op_mthi || w_op_mtlo);
    end

    // FSM state and status output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Datapath: operand capture, iteration, HI/LO update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= {CW{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_opb     <= {WIDTH{1'b0}};
            r_neg     <= 1'b0;
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
`ifdef MULDIV_DIVIDE_EN
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_a       <= {WIDTH{1'b0}};
`endif
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_cnt     <= {CW{1'b0}};
                r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                r_opb     <= w_b_mag;
                r_neg     <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIVIDE_EN
                r_is_div  <= w_op_div;
                r_neg_rem <= w_a_neg;
                r_dz      <= w_op_div && (b == {WIDTH{1'b0}});
                r_a       <= a;
`endif
            end
            if (start && w_op_mthi) begin
                r_hi <= a;
            end
            if (start && w_op_mtlo) begin
                r_lo <= a;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else if (r_state == S_FIX) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit (WIDTH=32). The driver issues requests and
// pushes the expected architectural effect (computed with plain 64-bit
// arithmetic) into a queue; the monitor pops entries when done/illegal pulse
// (or when an MTHI/MTLO takes effect) and checks hi/lo/busy every cycle.
// Honors MULDIV_DIVIDE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_ILL  = 2'd1;
    localparam logic [1:0] K_MTHI = 2'd2;
    localparam logic [1:0] K_MTLO = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [5:0]    funct = 6'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, illegal;
    logic [W-1:0]  hi, lo;

    item_t         sb[$];
    int            cyc = 0;
    int            free_cyc = 0;
    int            bfrom = 1;
    int            bto = 0;
    logic [31:0]   m_hi = '0;
    logic [31:0]   m_lo = '0;
    bit            mon_on = 1'b0;
    int            vecs = 0;
    int            errs = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .a(a), .b(b), .busy(busy), .done(done), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles required < 100000", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_pulse(input logic [1:0] k);
        if (k == K_DONE) return 2'b10;
        else if (k == K_ILL) return 2'b01;
        else return 2'b00;
    endfunction

    // Reference model: architectural effect of one request issued in cycle c.
    function automatic item_t model_op(input logic [5:0] f, input logic [31:0] av,
                                       input logic [31:0] bv, input int c);
        item_t       e;
        longint      sa, sbv, sq, sr;
        logic [63:0] p;
        sa  = $signed(av);
        sbv = $signed(bv);
        e.kind = K_DONE;
        e.cyc  = c + W + 2;
        e.hi   = '0;
        e.lo   = '0;
        case (f)
            6'h18: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            6'h19: begin p = {32'd0, av} * {32'd0, bv}; e.hi = p[63:32]; e.lo = p[31:0]; end
            6'h1A, 6'h1B: begin
                if (!DIV_EN) begin
                    e.kind = K_ILL; e.cyc = c + 1;
                end else if (bv == 32'd0) begin
                    e.hi = av; e.lo = 32'hFFFF_FFFF;
                end else if (f == 6'h1A) begin
                    sq = sa / sbv; sr = sa % sbv;
                    e.lo = sq[31:0]; e.hi = sr[31:0];
                end else begin
                    e.lo = av / bv; e.hi = av % bv;
                end
            end
            6'h11: begin e.kind = K_MTHI; e.cyc = c + 1; e.hi = av; end
            6'h13: begin e.kind = K_MTLO; e.cyc = c + 1; e.lo = av; end
            default: begin e.kind = K_ILL; e.cyc = c + 1; end
        endcase
        return e;
    endfunction

    // Issue one request when the model says the unit is free; inputs are
    // scrambled afterwards to show they are latched at acceptance.
    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        item_t e;
        while (cyc < free_cyc) begin
            @(posedge clk); #1;
        end
        start = 1'b1; funct = f; a = av; b = bv;
        e = model_op(f, av, bv, cyc);
        sb.push_back(e);
        if (e.kind == K_DONE) begin
            bfrom = cyc + 1; bto = cyc + W + 1; free_cyc = cyc + W + 2;
        end else begin
            free_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; funct = 6'($urandom);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: consumes scoreboard entries and checks state every cycle.
    always @(negedge clk) begin : mon
        item_t e;
        if (mon_on) begin
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, done, illegal}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {62'd0, done, illegal}, {62'd0, exp_pulse(e.kind)});
                    chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.kind == K_DONE) begin
                        m_hi = e.hi; m_lo = e.lo;
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.kind == K_MTHI) m_hi = e.hi;
                else if (e.kind == K_MTLO) m_lo = e.lo;
                else chk("missing_pulse", {62'd0, done, illegal}, {62'd0, exp_pulse(e.kind)});
            end
            chk("hi", {32'd0, hi}, {32'd0, m_hi});
            chk("lo", {32'd0, lo}, {32'd0, m_lo});
            chk("busy", {63'd0, busy}, {63'd0, (cyc >= bfrom && cyc <= bto)});
        end
    end

    initial begin
        logic [5:0] f;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
        free_cyc = cyc;

        // Signed multiply, then back-to-back multiply/divide.
        issue(6'h18, 32'hFFFF_FFFD, 32'h0000_0005);
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002);
        // Divide by zero and most-negative / -1.
        issue(6'h1B, 32'h0000_1234, 32'h0000_0000);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(6'h1A, 32'hFFFF_FF00, 32'h0000_0000);
        // Unsupported funct.
        issue(6'h20, 32'h1111_1111, 32'h2222_2222);
        // MTHI, then a multiply with start re-pulsed mid-run (ignored).
        issue(6'h11, 32'hA5A5_A5A5, 32'h0000_0000);
        issue(6'h18, 32'h0000_0007, 32'hFFFF_FFFE);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; funct = 6'h13; a = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        start = 1'b0;
        issue(6'h13, 32'h5A5A_5A5A, 32'h0000_0000);

        // Reset in cycle 10 of a multiply, with a competing MTHI start.
        issue(6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b1; funct = 6'h11; a = 32'h1234_5678;
        @(posedge clk); #1;
        sb.delete();
        m_hi = '0; m_lo = '0; bfrom = 1; bto = 0;
        start = 1'b0; rst_n = 1'b1;
        free_cyc = cyc;

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0, 7: f = 6'h18;
                1: f = 6'h19;
                2: f = 6'h1A;
                3: f = 6'h1B;
                4: f = 6'h11;
                5: f = 6'h13;
                default: begin
                    case ($urandom_range(0, 3))
                        0: f = 6'h20;
                        1: f = 6'h00;
                        2: f = 6'h1F;
                        default: f = 6'h10;
                    endcase
                end
            endcase
            issue(f, pick(), pick());
        end

        repeat (W + 6) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request valid; sampled only in IDLE.
REQ-005 SHALL have port funct  input  6  operation: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
REQ-006 SHALL have port a  input  WIDTH  rs operand / dividend / MTHI-MTLO data.
REQ-007 SHALL have port b  input  WIDTH  rt operand / divisor.
REQ-008 SHALL have port busy  output  1  operation in flight; pipeline stall source.
REQ-009 SHALL have port done  output  1  one-cycle pulse; new hi/lo visible.
REQ-010 SHALL have port illegal  output  1  one-cycle pulse; start with unsupported funct.
REQ-011 SHALL have ports hi, lo  output  WIDTH  registered HI/LO; MFHI/MFLO read these directly.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX; IDLE->RUN on start with MULT/MULTU/DIV/DIVU; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-013 SHALL take start at cycle 0, assert busy in cycles 1..WIDTH+1, update hi/lo at end of FIX, pulse done in cycle WIDTH+2.
REQ-014 SHALL perform one radix-2 shift-add step (multiply) or restoring subtract step (divide) per RUN cycle on operand magnitudes.
REQ-015 SHALL, for signed ops, negate product if operand signs differ, quotient if signs differ, remainder if dividend negative, during FIX.
REQ-016 SHALL place product bits [2*WIDTH-1:WIDTH] in hi, [WIDTH-1:0] in lo; quotient in lo, remainder in hi.
REQ-017 SHALL, on divide by zero (b==0, DIV or DIVU), set lo to all ones, hi to a, bypassing sign fix; latency unchanged.
REQ-018 SHALL, for DIV of most-negative by -1, yield lo=most-negative, hi=0.
REQ-019 SHALL write a to hi (MTHI) or lo (MTLO) on the start edge in IDLE; busy and done stay low.
REQ-020 SHALL ignore start while busy; no queueing; hi/lo hold previous values throughout RUN/FIX.
REQ-021 SHALL accept a new start in the done cycle (back-to-back).
REQ-022 SHALL pulse illegal the cycle after start in IDLE with any other funct; state and hi/lo unchanged.
REQ-023 SHALL latch funct, a, b at acceptance; input changes afterwards have no effect.
REQ-024 SHALL size the iteration counter $clog2(WIDTH)+1 bits; no wrap before terminal count.

Reset
REQ-025 SHALL, when rst_n low at a clk edge, force IDLE, hi=0, lo=0, busy=0, done=0, illegal=0.
REQ-026 SHALL abort an in-flight operation on reset mid-RUN/FIX with no hi/lo update and no done.
REQ-027 SHALL give reset priority over start in the same cycle.

Configuration
REQ-028 SHALL compile divide hardware only when macro MULDIV_DIVIDE_EN is defined.
REQ-029 SHALL, with MULDIV_DIVIDE_EN defined, support DIV/DIVU per REQ-012..018.
REQ-030 SHALL, without MULDIV_DIVIDE_EN, treat DIV/DIVU as unsupported per REQ-022; multiply/MTHI/MTLO unaffected.

Verification (WIDTH=32, macro defined unless noted)
REQ-031 SHALL cover MULT a=0xFFFFFFFD b=5 -> done at cycle 34, hi=0xFFFFFFFF lo=0xFFFFFFF1, busy cycles 1..33.
REQ-032 SHALL cover MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; then DIV a=0xFFFFFFF9 b=2 started in done cycle -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-033 SHALL cover DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x00001234; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-034 SHALL cover MTHI a=0xA5A5A5A5 then MULT started with start re-pulsed at cycle 5 -> second start ignored, hi=0xA5A5A5A5 until done.
REQ-035 SHALL cover rst_n low at cycle 10 of MULT -> next cycle busy=0 hi=lo=0, no done pulse.
REQ-036 SHALL cover macro undefined: DIV start -> illegal pulse 1 cycle, busy=0, hi/lo unchanged; funct 0x20 same either build.
